conv_img_sched: RTL and testbench

Sequencer that runs the multi-channel convolution engine (conv_img) over KN output kernels for one image.
- Per kernel: streams WW*WH weights from weight RAM, then the kernel bias from bias RAM, then the full DW*DH CH-channel image from image RAM.
- Collects engine results and generates result-RAM write strobes and addresses.
- Sits between the layer-level controller (start/done) and the engine plus its three read memories and one result memory.

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/conv_rd_stream.sv | 52 +++++
 rtl/conv_img_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_conv_img_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the convolution image sequencer and the engine bench:
//   - state_t : sequencer FSM state encoding
//   - out_dim : output dimension of a convolution along one axis
//   - num_weights / num_pixels / num_results : per-kernel beat counts
//   - cnt_width : counter width able to hold 0..n-1
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    FIN    = 3'd5
  } state_t;

  // Output size along one axis; pd=1 pads so that a stride-1 output
  // keeps the input size.
  function automatic int out_dim(input int d, input int w, input int s, input int pd);
    return (d + pd * (w - 1) - w) / s + 1;
  endfunction

  function automatic int num_weights(input int ww, input int wh);
    return ww * wh;
  endfunction

  function automatic int num_pixels(input int dw, input int dh);
    return dw * dh;
  endfunction

  function automatic int num_results(input int dw, input int dh, input int ww, input int wh,
                                     input int sw, input int sh, input int pd);
    return out_dim(dw, ww, sw, pd) * out_dim(dh, wh, sh, pd);
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_rd_stream.sv
// conv_rd_stream
// Sequential read streamer for a memory with 1-cycle read latency. While
// 'en' is high it walks addresses base+0 .. base+LEN-1, one per cycle; the
// matching valid/last strobes come out one cycle later so they line up with
// the read data returned by the RAM.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   en           : stream active (one address per cycle while high)
//   base         : base address added to the running count
//   addr         : read address (0 while idle)
//   at_end       : current address is the last one (same cycle as addr)
//   valid, last  : read-data strobes, delayed 1 cycle from addr
module conv_rd_stream import conv_pkg::*; #(
  parameter int AW  = 14,
  parameter int LEN = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          en,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] addr,
  output logic          at_end,
  output logic          valid,
  output logic          last
);

  localparam int CW = cnt_width(LEN);

  logic [CW-1:0] cnt;

  assign at_end = en && (cnt == CW'(LEN - 1));
  assign addr   = en ? (base + AW'(cnt)) : '0;

  // The count restarts whenever the stream is idle, so each activation
  // always begins at base+0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else begin
      valid <= en;
      last  <= at_end;
      if (!en || at_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_img_sched.sv
// conv_img_sched
// Runs the multi-channel convolution engine over KN kernels for one image.
// For each kernel: stream NW weights, fetch the bias, stream NP image words,
// then wait for the engine's last result. Engine results are written to the
// result RAM at k*NR + r.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_start, i_kernel_num   : start pulse (IDLE only) and kernel count KN
//   o_busy, o_done, o_err   : status; o_err is a sticky result-count mismatch
//   o_kernel_idx            : kernel currently being processed
//   o_weight_addr/i_weight_rdata, o_bias_addr/i_bias_rdata,
//   o_img_addr/i_img_rdata  : read RAM ports (1-cycle latency)
//   o_weight_*, o_bias_*, o_data_* : streams to the engine
//   i_res_*                 : results from the engine
//   o_wr_en/o_wr_addr/o_wr_data : result RAM write port
module conv_img_sched import conv_pkg::*; #(
  parameter int AW = 14,
  parameter int BW = 8,
  parameter int CH = 3,
  parameter int DW = 64,
  parameter int DH = 64,
  parameter int WW = 3,
  parameter int WH = 3,
  parameter int SW = 1,
  parameter int SH = 1,
  parameter int PD = 1,
  parameter int KW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [KW-1:0]    i_kernel_num,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [KW-1:0]    o_kernel_idx,
  output logic [AW-1:0]    o_weight_addr,
  input  logic [BW-1:0]    i_weight_rdata,
  output logic [AW-1:0]    o_bias_addr,
  input  logic [BW-1:0]    i_bias_rdata,
  output logic [AW-1:0]    o_img_addr,
  input  logic [CH*BW-1:0] i_img_rdata,
  output logic             o_weight_valid,
  output logic             o_weight_last,
  output logic [BW-1:0]    o_weight,
  output logic             o_bias_valid,
  output logic [BW-1:0]    o_bias,
  output logic             o_data_valid,
  output logic             o_data_last,
  output logic [CH*BW-1:0] o_data,
  input  logic             i_res_valid,
  input  logic             i_res_last,
  input  logic [BW-1:0]    i_res,
  output logic             o_wr_en,
  output logic [AW-1:0]    o_wr_addr,
  output logic [BW-1:0]    o_wr_data
);

  localparam int NW = num_weights(WW, WH);
  localparam int NP = num_pixels(DW, DH);
  localparam int NR = num_results(DW, DH, WW, WH, SW, SH, PD);

  state_t        state;
  state_t        state_nx;
  logic [KW-1:0] kn_q;
  logic [KW-1:0] k_q;
  logic [AW-1:0] w_base;
  logic [AW-1:0] wr_base;
  logic [AW-1:0] r_cnt;
  logic          res_seen;
  logic          bias_cap;
  logic          w_en;
  logic          d_en;
  logic          w_end;
  logic          d_end;
  logic          start_ok;
  logic          res_act;
  logic          res_last_evt;
  logic          drain_exit;
  logic          more;

  assign start_ok     = (state == IDLE) && i_start;
  assign res_act      = i_res_valid && (state != IDLE);
  assign res_last_evt = res_act && i_res_last;
  // A last result seen earlier (during STREAM) satisfies DRAIN on entry.
  assign drain_exit   = (state == DRAIN) && (res_seen || res_last_evt);
  assign more         = ({1'b0, k_q} + {{KW{1'b0}}, 1'b1}) < {1'b0, kn_q};

  assign o_kernel_idx = k_q;
  assign o_bias_addr  = AW'(k_q);
  assign o_weight     = o_weight_valid ? i_weight_rdata : '0;
  assign o_data       = o_data_valid ? i_img_rdata : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    o_busy   = (state != IDLE);
    w_en     = (state == LOAD_W);
    d_en     = (state == STREAM);
    unique case (state)
      IDLE:    if (i_start && (i_kernel_num != '0)) state_nx = LOAD_W;
      LOAD_W:  if (w_end) state_nx = LOAD_B;
      LOAD_B:  state_nx = STREAM;
      STREAM:  if (d_end) state_nx = DRAIN;
      DRAIN:   if (drain_exit) state_nx = more ? LOAD_W : FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  conv_rd_stream #(.AW(AW), .LEN(NW)) u_weight_stream (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .en     (w_en),
    .base   (w_base),
    .addr   (o_weight_addr),
    .at_end (w_end),
    .valid  (o_weight_valid),
    .last   (o_weight_last)
  );

  conv_rd_stream #(.AW(AW), .LEN(NP)) u_img_stream (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .en     (d_en),
    .base   ('0),
    .addr   (o_img_addr),
    .at_end (d_end),
    .valid  (o_data_valid),
    .last   (o_data_last)
  );

  // Kernel bookkeeping. Weight and result bases advance by NW/NR per kernel
  // instead of multiplying k, which gives the same AW-bit wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      kn_q    <= '0;
      k_q     <= '0;
      w_base  <= '0;
      wr_base <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (start_ok) begin
        kn_q    <= i_kernel_num;
        k_q     <= '0;
        w_base  <= '0;
        wr_base <= '0;
        o_err   <= 1'b0;
        if (i_kernel_num == '0) begin
          o_done <= 1'b1;
        end
      end
      if (state == FIN) begin
        o_done <= 1'b1;
      end
      if (drain_exit) begin
        k_q     <= k_q + KW'(1);
        w_base  <= w_base + AW'(NW);
        wr_base <= wr_base + AW'(NR);
      end
      if (res_last_evt && (r_cnt != AW'(NR - 1))) begin
        o_err <= 1'b1;
      end
    end
  end

  // The bias RAM returns data the cycle after LOAD_B; capture it then so it
  // becomes visible together with the first pixel beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bias_cap     <= 1'b0;
      o_bias       <= '0;
      o_bias_valid <= 1'b0;
    end else begin
      bias_cap <= (state == LOAD_B);
      if (bias_cap) begin
        o_bias       <= i_bias_rdata;
        o_bias_valid <= 1'b1;
      end else if (drain_exit) begin
        o_bias_valid <= 1'b0;
      end
    end
  end

  // Result collection. The last result resets r immediately; res_seen
  // remembers it in case it arrived before DRAIN was reached.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      r_cnt     <= '0;
      res_seen  <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      if (start_ok) begin
        r_cnt <= '0;
      end
      if (res_act) begin
        o_wr_en   <= 1'b1;
        o_wr_addr <= wr_base + r_cnt;
        o_wr_data <= i_res;
        r_cnt     <= i_res_last ? '0 : (r_cnt + AW'(1));
      end
      if (drain_exit) begin
        res_seen <= 1'b0;
      end else if (res_last_evt) begin
        res_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_img_sched.sv
// tb_conv_img_sched
// Directed bench for conv_img_sched with a 4x4 image, 3x3 kernel, padding on
// (NW=9, NP=16, NR=16). Behavioural RAMs return address-derived data and a
// 5-cycle engine model turns each pixel beat into one result.
module tb_conv_img_sched;

  localparam int AW = 14;
  localparam int BW = 8;
  localparam int CH = 3;
  localparam int KW = 8;
  localparam int NW = 9;
  localparam int NP = 16;
  localparam int NR = 16;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic [KW-1:0]    i_kernel_num = '0;
  logic             o_busy, o_done, o_err;
  logic [KW-1:0]    o_kernel_idx;
  logic [AW-1:0]    o_weight_addr, o_bias_addr, o_img_addr;
  logic [BW-1:0]    weight_rdata = '0;
  logic [BW-1:0]    bias_rdata = '0;
  logic [CH*BW-1:0] img_rdata = '0;
  logic             o_weight_valid, o_weight_last;
  logic [BW-1:0]    o_weight;
  logic             o_bias_valid;
  logic [BW-1:0]    o_bias;
  logic             o_data_valid, o_data_last;
  logic [CH*BW-1:0] o_data;
  logic             res_valid, res_last;
  logic [BW-1:0]    res;
  logic             o_wr_en;
  logic [AW-1:0]    o_wr_addr;
  logic [BW-1:0]    o_wr_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // scoreboard
  int w_g, w_pos, w_bad, k_bad, d_g, d_pos, d_bad, b_bad;
  int wr_n, wr_bad, done_n, done_busy, busy_n;
  int start_cyc, first_w_cyc, first_d_cyc, done_cyc, err_at_k1;
  logic [23:0] exp_d;

  // engine model and injection
  logic       drop_mode = 1'b0;
  logic [4:0] ev = '0;
  logic [4:0] el = '0;
  logic [7:0] ed [5];
  int         epix = 0;
  logic       inj_v = 1'b0;
  logic       inj_l = 1'b0;
  logic [7:0] inj_d = '0;

  conv_img_sched #(
    .AW(AW), .BW(BW), .CH(CH), .DW(4), .DH(4), .WW(3), .WH(3),
    .SW(1), .SH(1), .PD(1), .KW(KW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_kernel_num(i_kernel_num),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_kernel_idx(o_kernel_idx),
    .o_weight_addr(o_weight_addr), .i_weight_rdata(weight_rdata),
    .o_bias_addr(o_bias_addr), .i_bias_rdata(bias_rdata),
    .o_img_addr(o_img_addr), .i_img_rdata(img_rdata),
    .o_weight_valid(o_weight_valid), .o_weight_last(o_weight_last), .o_weight(o_weight),
    .o_bias_valid(o_bias_valid), .o_bias(o_bias),
    .o_data_valid(o_data_valid), .o_data_last(o_data_last), .o_data(o_data),
    .i_res_valid(res_valid), .i_res_last(res_last), .i_res(res),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // RAMs with 1-cycle read latency and address-derived contents
  always @(posedge i_clk) begin
    weight_rdata <= o_weight_addr[7:0] + 8'h10;
    bias_rdata   <= o_bias_addr[7:0] + 8'hB0;
    img_rdata    <= {o_img_addr[7:0] + 8'd2, o_img_addr[7:0] + 8'd1, o_img_addr[7:0]};
  end

  // engine: result = pixel low byte + bias, 5 cycles later
  always @(posedge i_clk) begin
    ev <= {ev[3:0], o_data_valid && !(drop_mode && (o_kernel_idx == 8'd0) && (epix == 3))};
    el <= {el[3:0], o_data_valid && o_data_last};
    ed[0] <= o_data[7:0] + o_bias;
    for (int i = 1; i < 5; i++) ed[i] <= ed[i-1];
    if (i_rst) epix <= 0;
    else if (o_data_valid) epix <= o_data_last ? 0 : epix + 1;
  end

  assign res_valid = ev[4] | inj_v;
  assign res_last  = el[4] | inj_l;
  assign res       = inj_v ? inj_d : ed[4];

  always @(negedge i_clk) begin
    if (o_weight_valid) begin
      if (o_weight !== 8'(w_g + 16)) w_bad++;
      if (o_weight_last !== (w_pos == NW - 1)) w_bad++;
      if (o_kernel_idx !== 8'(w_g / NW)) k_bad++;
      if (w_g == 0) first_w_cyc = cyc;
      if (w_g == NW) err_at_k1 = int'(o_err);
      w_g++;
      w_pos = (w_pos == NW - 1) ? 0 : w_pos + 1;
    end
    if (o_data_valid) begin
      exp_d = {8'(d_pos + 2), 8'(d_pos + 1), 8'(d_pos)};
      if (o_data !== exp_d) d_bad++;
      if (o_data_last !== (d_pos == NP - 1)) d_bad++;
      if (!o_bias_valid || (o_bias !== 8'(8'hB0 + d_g / NP))) b_bad++;
      if (d_g == 0) first_d_cyc = cyc;
      d_g++;
      d_pos = (d_pos == NP - 1) ? 0 : d_pos + 1;
    end
    if (o_wr_en) begin
      if (o_wr_addr !== 14'(wr_n)) wr_bad++;
      if (o_wr_data !== 8'(wr_n % NR + 8'hB0 + wr_n / NR)) wr_bad++;
      wr_n++;
    end
    if (o_done) begin
      done_n++;
      done_cyc = cyc;
      if (o_busy) done_busy++;
    end
    if (o_busy) busy_n++;
    if (i_start && !o_busy) start_cyc = cyc;
  end

  task automatic clearScoreboard();
    w_g = 0; w_pos = 0; w_bad = 0; k_bad = 0;
    d_g = 0; d_pos = 0; d_bad = 0; b_bad = 0;
    wr_n = 0; wr_bad = 0; done_n = 0; done_busy = 0; busy_n = 0;
    start_cyc = -100; first_w_cyc = -100; first_d_cyc = -100; done_cyc = -100;
    err_at_k1 = -1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [KW-1:0] kn);
    i_kernel_num = kn;
    i_start = 1'b1;
    cycles(1);
    i_start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      cycles(1);
      n++;
    end
    if (done_n == 0) checkOutput("done_timeout", 0, 1);
    cycles(3);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) ed[i] = '0;
    clearScoreboard();
    cycles(4);

    $display("[TB] reset state");
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_err", o_err, 0);
    checkOutput("rst_wvalid", o_weight_valid, 0);
    checkOutput("rst_dvalid", o_data_valid, 0);
    checkOutput("rst_bvalid", o_bias_valid, 0);
    checkOutput("rst_wr_en", o_wr_en, 0);
    checkOutput("rst_kidx", o_kernel_idx, 0);
    i_rst = 1'b0;
    cycles(2);

    $display("[TB] single kernel, with stray start during STREAM");
    clearScoreboard();
    applyStimulus(8'd1);
    begin
      int n = 0;
      while (d_g < 4 && n < 200) begin cycles(1); n++; end
    end
    i_kernel_num = 8'd5;
    i_start = 1'b1;
    cycles(1);
    i_start = 1'b0;
    waitDone(300);
    checkOutput("k1_wbeats", w_g, 9);
    checkOutput("k1_wbad", w_bad, 0);
    checkOutput("k1_wlat", first_w_cyc - start_cyc, 2);
    checkOutput("k1_dbeats", d_g, 16);
    checkOutput("k1_dbad", d_bad, 0);
    checkOutput("k1_dlat", first_d_cyc - start_cyc, 12);
    checkOutput("k1_bias", b_bad, 0);
    checkOutput("k1_writes", wr_n, 16);
    checkOutput("k1_wrbad", wr_bad, 0);
    checkOutput("k1_done", done_n, 1);
    checkOutput("k1_done_busy", done_busy, 0);
    checkOutput("k1_err", o_err, 0);
    checkOutput("k1_bvalid_end", o_bias_valid, 0);
    checkOutput("k1_busy_end", o_busy, 0);

    $display("[TB] three kernels");
    clearScoreboard();
    applyStimulus(8'd3);
    waitDone(600);
    checkOutput("k3_wbeats", w_g, 27);
    checkOutput("k3_wbad", w_bad, 0);
    checkOutput("k3_kidx", k_bad, 0);
    checkOutput("k3_dbeats", d_g, 48);
    checkOutput("k3_dbad", d_bad, 0);
    checkOutput("k3_bias", b_bad, 0);
    checkOutput("k3_writes", wr_n, 48);
    checkOutput("k3_wrbad", wr_bad, 0);
    checkOutput("k3_done", done_n, 1);
    checkOutput("k3_err", o_err, 0);

    $display("[TB] zero kernels");
    clearScoreboard();
    applyStimulus(8'd0);
    cycles(5);
    checkOutput("k0_done", done_n, 1);
    checkOutput("k0_done_lat", done_cyc - start_cyc, 1);
    checkOutput("k0_busy", busy_n, 0);
    checkOutput("k0_reads", w_g + d_g, 0);

    $display("[TB] short result count");
    clearScoreboard();
    drop_mode = 1'b1;
    applyStimulus(8'd2);
    waitDone(500);
    drop_mode = 1'b0;
    checkOutput("short_err_k1", err_at_k1, 1);
    checkOutput("short_err_end", o_err, 1);
    checkOutput("short_writes", wr_n, 31);
    checkOutput("short_done", done_n, 1);
    clearScoreboard();
    applyStimulus(8'd1);
    cycles(1);
    checkOutput("short_err_clr", o_err, 0);
    waitDone(300);
    checkOutput("short_rerun_wr", wr_n, 16);
    checkOutput("short_rerun_err", o_err, 0);

    $display("[TB] reset during kernel 1 stream");
    clearScoreboard();
    applyStimulus(8'd3);
    begin
      int n = 0;
      while (!(o_kernel_idx == 8'd1 && o_data_valid) && n < 300) begin cycles(1); n++; end
      if (n >= 300) checkOutput("rst_wait_timeout", 0, 1);
    end
    cycles(3);
    i_rst = 1'b1;
    cycles(1);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_dvalid", o_data_valid, 0);
    checkOutput("abort_wvalid", o_weight_valid, 0);
    checkOutput("abort_bvalid", o_bias_valid, 0);
    checkOutput("abort_kidx", o_kernel_idx, 0);
    i_rst = 1'b0;
    clearScoreboard();
    cycles(10);
    checkOutput("abort_idle_wr", wr_n, 0);
    checkOutput("abort_no_done", done_n, 0);
    applyStimulus(8'd1);
    waitDone(300);
    checkOutput("abort_rerun_w", w_g, 9);
    checkOutput("abort_rerun_wbad", w_bad, 0);
    checkOutput("abort_rerun_wr", wr_n, 16);
    checkOutput("abort_rerun_wrbad", wr_bad, 0);
    checkOutput("abort_rerun_err", o_err, 0);

    $display("[TB] results injected while idle");
    clearScoreboard();
    inj_d = 8'h55;
    inj_v = 1'b1;
    cycles(2);
    inj_l = 1'b1;
    cycles(1);
    inj_v = 1'b0;
    inj_l = 1'b0;
    cycles(3);
    checkOutput("idle_res_wr", wr_n, 0);
    applyStimulus(8'd1);
    waitDone(300);
    checkOutput("idle_rerun_wr", wr_n, 16);
    checkOutput("idle_rerun_wrbad", wr_bad, 0);
    checkOutput("idle_rerun_err", o_err, 0);
    checkOutput("idle_rerun_done", done_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
